// File: rtl/simple_alu_pipe_if.sv
// simple_alu_pipe_if: issue-side and result-side handshake bundle for the
// pipelined integer ALU. Also carries the shared opcode/flag width macros
// and opcode encodings, guarded so other files may provide them first.

`ifndef SIMPLE_ALU_PIPE_DEFS
`define SIMPLE_ALU_PIPE_DEFS
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`define ALU_OP_NOP   6'd0
`define ALU_OP_ADD   6'd1
`define ALU_OP_ADDU  6'd2
`define ALU_OP_ADDI  6'd3
`define ALU_OP_ADDIU 6'd4
`define ALU_OP_SUB   6'd5
`define ALU_OP_SUBU  6'd6
`define ALU_OP_AND   6'd7
`define ALU_OP_OR    6'd8
`define ALU_OP_XOR   6'd9
`define ALU_OP_NOR   6'd10
`define ALU_OP_ANDI  6'd11
`define ALU_OP_ORI   6'd12
`define ALU_OP_XORI  6'd13
`define ALU_OP_SLT   6'd14
`define ALU_OP_SLTU  6'd15
`define ALU_OP_SLTI  6'd16
`define ALU_OP_SLTIU 6'd17
`define ALU_OP_SLL   6'd18
`define ALU_OP_SRL   6'd19
`define ALU_OP_SRA   6'd20
`define ALU_OP_SLLV  6'd21
`define ALU_OP_SRLV  6'd22
`define ALU_OP_SRAV  6'd23
`define ALU_OP_MFHI  6'd24
`define ALU_OP_MTHI  6'd25
`define ALU_OP_MFLO  6'd26
`define ALU_OP_MTLO  6'd27
`define ALU_OP_LUI   6'd28
`endif

interface simple_alu_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 7
);
  logic                        flush_i;
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [DATA_W-1:0]           data1_i;
  logic [DATA_W-1:0]           data2_i;
  logic [IMM_W-1:0]            immd_i;
  logic [`SIZE_OPCODE_I-1:0]   opcode_i;
  logic [TAG_W-1:0]            tag_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [DATA_W-1:0]           result_o;
  logic [`EXECUTION_FLAGS-1:0] flags_o;
  logic [TAG_W-1:0]            tag_o;

  modport master (
    output flush_i, in_valid_i, data1_i, data2_i, immd_i, opcode_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, flags_o, tag_o
  );

  modport slave (
    input  flush_i, in_valid_i, data1_i, data2_i, immd_i, opcode_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, flags_o, tag_o
  );
endinterface

// File: rtl/simple_alu_pipe.sv
// simple_alu_pipe: two-stage pipelined integer ALU (operand register, then
// result register) with valid/ready flow control and mispredict flush.
// Optional macro SIMPLE_ALU_OVF_EN: ADD/ADDI/SUB report signed overflow in
// the exception flag instead of carry/borrow out.

module simple_alu_pipe #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int TAG_W   = 7,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input logic              clk,
  input logic              reset,
  simple_alu_pipe_if.slave bus
);

  logic                        s2_adv;
  logic                        accept;
  logic                        adv_p1;
  logic                        vld_p1_q, vld_p1_d;
  logic                        vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0]           data1_p1_q;
  logic [DATA_W-1:0]           data2_p1_q;
  logic [IMM_W-1:0]            imm_p1_q;
  logic [`SIZE_OPCODE_I-1:0]   opc_p1_q;
  logic [TAG_W-1:0]            tag_p1_q;
  logic [DATA_W-1:0]           result_p2_q, result_p2_d;
  logic [`EXECUTION_FLAGS-1:0] flags_p2_q, flags_p2_d;
  logic [TAG_W-1:0]            tag_p2_q;

  logic [DATA_W-1:0]           sext_imm;
  logic [DATA_W-1:0]           zext_imm;
  logic signed [DATA_W-1:0]    a_s;
  logic signed [DATA_W-1:0]    b_s;
  logic signed [DATA_W-1:0]    simm_s;
  logic [SHAMT_W-1:0]          shamt_i;
  logic [SHAMT_W-1:0]          shamt_r;
  logic [DATA_W:0]             add_rr;
  logic [DATA_W:0]             add_ri;
  logic [DATA_W:0]             sub_rr;
  logic                        exc_add_rr;
  logic                        exc_add_ri;
  logic                        exc_sub_rr;

  // S2 may take a new op when empty or when its current op is being consumed
  assign s2_adv         = !vld_p2_q || bus.out_ready_i;
  assign bus.in_ready_o = !vld_p1_q || s2_adv;
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign adv_p1         = vld_p1_q && s2_adv;

  // Valid next-state: flush kills both stages, including an op offered this cycle
  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (bus.flush_i) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
    end else begin
      if (s2_adv) vld_p2_d = vld_p1_q;
      if (accept) vld_p1_d = 1'b1;
      else if (s2_adv) vld_p1_d = 1'b0;
    end
  end

  // Stage valid registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- S1: operand capture on accepted handshake ----
  always_ff @(posedge clk) begin
    if (accept) begin
      data1_p1_q <= bus.data1_i;
      data2_p1_q <= bus.data2_i;
      imm_p1_q   <= bus.immd_i;
      opc_p1_q   <= bus.opcode_i;
      tag_p1_q   <= bus.tag_i;
    end
  end

  assign sext_imm = {{(DATA_W-IMM_W){imm_p1_q[IMM_W-1]}}, imm_p1_q};
  assign zext_imm = {{(DATA_W-IMM_W){1'b0}}, imm_p1_q};
  assign a_s      = data1_p1_q;
  assign b_s      = data2_p1_q;
  assign simm_s   = sext_imm;
  assign shamt_i  = imm_p1_q[SHAMT_W-1:0];
  assign shamt_r  = data1_p1_q[SHAMT_W-1:0];
  assign add_rr   = {1'b0, data1_p1_q} + {1'b0, data2_p1_q};
  assign add_ri   = {1'b0, data1_p1_q} + {1'b0, sext_imm};
  assign sub_rr   = {1'b0, data1_p1_q} - {1'b0, data2_p1_q};

`ifdef SIMPLE_ALU_OVF_EN
  assign exc_add_rr = (data1_p1_q[DATA_W-1] == data2_p1_q[DATA_W-1]) &&
                      (add_rr[DATA_W-1] != data1_p1_q[DATA_W-1]);
  assign exc_add_ri = (data1_p1_q[DATA_W-1] == sext_imm[DATA_W-1]) &&
                      (add_ri[DATA_W-1] != data1_p1_q[DATA_W-1]);
  assign exc_sub_rr = (data1_p1_q[DATA_W-1] != data2_p1_q[DATA_W-1]) &&
                      (sub_rr[DATA_W-1] != data1_p1_q[DATA_W-1]);
`else
  // Top bit of the widened sum/difference is carry out / borrow out
  assign exc_add_rr = add_rr[DATA_W];
  assign exc_add_ri = add_ri[DATA_W];
  assign exc_sub_rr = sub_rr[DATA_W];
`endif

  // ALU datapath: result and flags {0, executed, 0, valid, exception, mispredict}
  always_comb begin
    result_p2_d = '0;
    flags_p2_d  = 6'b010100;
    case (opc_p1_q)
      `ALU_OP_ADD:   begin result_p2_d = add_rr[DATA_W-1:0]; flags_p2_d[1] = exc_add_rr; end
      `ALU_OP_ADDI:  begin result_p2_d = add_ri[DATA_W-1:0]; flags_p2_d[1] = exc_add_ri; end
      `ALU_OP_SUB:   begin result_p2_d = sub_rr[DATA_W-1:0]; flags_p2_d[1] = exc_sub_rr; end
      `ALU_OP_ADDU:  result_p2_d = add_rr[DATA_W-1:0];
      `ALU_OP_ADDIU: result_p2_d = add_ri[DATA_W-1:0];
      `ALU_OP_SUBU:  result_p2_d = sub_rr[DATA_W-1:0];
      `ALU_OP_AND:   result_p2_d = data1_p1_q & data2_p1_q;
      `ALU_OP_OR:    result_p2_d = data1_p1_q | data2_p1_q;
      `ALU_OP_XOR:   result_p2_d = data1_p1_q ^ data2_p1_q;
      `ALU_OP_NOR:   result_p2_d = ~(data1_p1_q | data2_p1_q);
      `ALU_OP_ANDI:  result_p2_d = data1_p1_q & zext_imm;
      `ALU_OP_ORI:   result_p2_d = data1_p1_q | zext_imm;
      `ALU_OP_XORI:  result_p2_d = data1_p1_q ^ zext_imm;
      `ALU_OP_SLT:   result_p2_d = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      `ALU_OP_SLTI:  result_p2_d = {{(DATA_W-1){1'b0}}, (a_s < simm_s)};
      `ALU_OP_SLTU:  result_p2_d = {{(DATA_W-1){1'b0}}, (data1_p1_q < data2_p1_q)};
      `ALU_OP_SLTIU: result_p2_d = {{(DATA_W-1){1'b0}}, (data1_p1_q < zext_imm)};
      `ALU_OP_SLL:   result_p2_d = data1_p1_q << shamt_i;
      `ALU_OP_SRL:   result_p2_d = data1_p1_q >> shamt_i;
      `ALU_OP_SRA:   result_p2_d = a_s >>> shamt_i;
      `ALU_OP_SLLV:  result_p2_d = data2_p1_q << shamt_r;
      `ALU_OP_SRLV:  result_p2_d = data2_p1_q >> shamt_r;
      `ALU_OP_SRAV:  result_p2_d = b_s >>> shamt_r;
      `ALU_OP_MFHI, `ALU_OP_MTHI,
      `ALU_OP_MFLO, `ALU_OP_MTLO: result_p2_d = data1_p1_q;
      `ALU_OP_LUI:   result_p2_d = {imm_p1_q, {(DATA_W-IMM_W){1'b0}}};
      `ALU_OP_NOP:   flags_p2_d = 6'b000100;
      default:       flags_p2_d = 6'b000000;
    endcase
  end

  // ---- S2: result register, holds while stalled ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_p2_q <= '0;
      flags_p2_q  <= '0;
      tag_p2_q    <= '0;
    end else if (adv_p1) begin
      result_p2_q <= result_p2_d;
      flags_p2_q  <= flags_p2_d;
      tag_p2_q    <= tag_p1_q;
    end
  end

  assign bus.out_valid_o = vld_p2_q;
  assign bus.result_o    = result_p2_q;
  assign bus.flags_o     = flags_p2_q;
  assign bus.tag_o       = tag_p2_q;

endmodule

// File: tb/tb_simple_alu_pipe.sv
// tb_simple_alu_pipe: directed self-checking bench for simple_alu_pipe.

`ifndef SIMPLE_ALU_PIPE_DEFS
`define SIMPLE_ALU_PIPE_DEFS
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`define ALU_OP_NOP   6'd0
`define ALU_OP_ADD   6'd1
`define ALU_OP_ADDU  6'd2
`define ALU_OP_ADDI  6'd3
`define ALU_OP_ADDIU 6'd4
`define ALU_OP_SUB   6'd5
`define ALU_OP_SUBU  6'd6
`define ALU_OP_AND   6'd7
`define ALU_OP_OR    6'd8
`define ALU_OP_XOR   6'd9
`define ALU_OP_NOR   6'd10
`define ALU_OP_ANDI  6'd11
`define ALU_OP_ORI   6'd12
`define ALU_OP_XORI  6'd13
`define ALU_OP_SLT   6'd14
`define ALU_OP_SLTU  6'd15
`define ALU_OP_SLTI  6'd16
`define ALU_OP_SLTIU 6'd17
`define ALU_OP_SLL   6'd18
`define ALU_OP_SRL   6'd19
`define ALU_OP_SRA   6'd20
`define ALU_OP_SLLV  6'd21
`define ALU_OP_SRLV  6'd22
`define ALU_OP_SRAV  6'd23
`define ALU_OP_MFHI  6'd24
`define ALU_OP_MTHI  6'd25
`define ALU_OP_MFLO  6'd26
`define ALU_OP_MTLO  6'd27
`define ALU_OP_LUI   6'd28
`endif

module tb_simple_alu_pipe;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int TAG_W  = 7;
  localparam logic [5:0] F_OK  = 6'b010100;
  localparam logic [5:0] F_EXC = 6'b010110;
  localparam logic [5:0] F_NOP = 6'b000100;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [6:0]  s_out_tag[$];
  logic [31:0] s_out_res[$];
  int          s_out_cyc[$];
  int          s_acc_cyc[$];
  int          s_unstable;
  int          s_stalled;
  int          s_notready;

  simple_alu_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .TAG_W(TAG_W)) bus ();

  simple_alu_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.data1_i     = '0;
    bus.data2_i     = '0;
    bus.immd_i      = '0;
    bus.opcode_i    = `ALU_OP_NOP;
    bus.tag_i       = '0;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [15:0] imm, input logic [6:0] tag);
    bus.opcode_i   = op;
    bus.data1_i    = d1;
    bus.data2_i    = d2;
    bus.immd_i     = imm;
    bus.tag_i      = tag;
    bus.in_valid_i = 1'b1;
  endtask

  // Issue one op into an empty pipe and wait (bounded) for its result
  task automatic run_op(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [15:0] imm, input logic [6:0] tag,
                        output logic [31:0] res, output logic [5:0] flg,
                        output logic [6:0] tg, output int lat);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    drive(op, d1, d2, imm, tag);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    lat = 1;
    while (!bus.out_valid_o && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result_o;
    flg = bus.flags_o;
    tg  = bus.tag_o;
  endtask

  // Stream n ADDs (data1=tag<<4, data2=tag, so result = tag*17) under an out_ready stall mask
  task automatic stream(input int n, input logic [6:0] first_tag, input logic [31:0] stall_mask,
                        input int ncyc);
    int idx = 0;
    logic pv = 1'b0;
    logic [31:0] pr = '0;
    logic [6:0]  pt = '0;
    logic [5:0]  pf = '0;
    logic [6:0]  t;
    s_out_tag.delete(); s_out_res.delete(); s_out_cyc.delete(); s_acc_cyc.delete();
    s_unstable = 0; s_stalled = 0; s_notready = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.out_ready_i = !stall_mask[c];
      if (idx < n) begin
        t = 7'(first_tag + idx);
        drive(`ALU_OP_ADD, {21'd0, t, 4'd0}, {25'd0, t}, 16'd0, t);
      end else begin
        bus.in_valid_i = 1'b0;
      end
      #1;
      if (pv && (bus.out_valid_o !== 1'b1 || bus.result_o !== pr || bus.tag_o !== pt || bus.flags_o !== pf))
        s_unstable++;
      pv = bus.out_valid_o && !bus.out_ready_i;
      if (pv) s_stalled++;
      pr = bus.result_o; pt = bus.tag_o; pf = bus.flags_o;
      if (bus.out_valid_o && bus.out_ready_i) begin
        s_out_tag.push_back(bus.tag_o);
        s_out_res.push_back(bus.result_o);
        s_out_cyc.push_back(c);
      end
      if (bus.in_valid_i && !bus.in_ready_o) s_notready++;
      if (bus.in_valid_i && bus.in_ready_o) begin
        s_acc_cyc.push_back(c);
        idx++;
      end
    end
    @(negedge clk);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r; logic [5:0] f; logic [6:0] t; int l;
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid_o); end
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL rst_result: got %h expected 0", bus.result_o); end
    checks++; if (bus.flags_o !== 6'h0) begin errors++; $display("FAIL rst_flags: got %b expected 0", bus.flags_o); end
    checks++; if (bus.tag_o !== 7'h0) begin errors++; $display("FAIL rst_tag: got %h expected 0", bus.tag_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready_o); end
    reset = 1'b1;
    @(negedge clk); drive(`ALU_OP_ADD, 32'd100, 32'd1, 16'd0, 7'd3);
    @(negedge clk); drive(`ALU_OP_ADD, 32'd200, 32'd2, 16'd0, 7'd4);
    @(negedge clk); bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    #1;
    checks++; if (bus.out_valid_o !== 1'b1 || bus.tag_o !== 7'd3 || bus.result_o !== 32'd101) begin
      errors++; $display("FAIL inflight_before_reset: got v=%b tag=%0d res=%0d expected v=1 tag=3 res=101", bus.out_valid_o, bus.tag_o, bus.result_o); end
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid_o); end
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h expected 0", bus.result_o); end
    checks++; if (bus.flags_o !== 6'h0) begin errors++; $display("FAIL midrst_flags: got %b expected 0", bus.flags_o); end
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_stale: got %b expected 0", bus.out_valid_o); end
    run_op(`ALU_OP_ADD, 32'd2, 32'd3, 16'd0, 7'd5, r, f, t, l);
    checks++; if (l !== 2) begin errors++; $display("FAIL post_rst_latency: got %0d expected 2", l); end
    checks++; if (r !== 32'd5 || t !== 7'd5 || f !== F_OK) begin
      errors++; $display("FAIL post_rst_op: got res=%0d tag=%0d flg=%b expected res=5 tag=5 flg=%b", r, t, f, F_OK); end
  endtask

  task automatic test_slt();
    logic [31:0] r; logic [5:0] f; logic [6:0] t; int l;
    run_op(`ALU_OP_SLT, 32'd5, 32'd7, 16'd0, 7'd1, r, f, t, l);
    checks++; if (r !== 32'd1 || f !== F_OK) begin errors++; $display("FAIL slt_5_7: got %h/%b expected 1/%b", r, f, F_OK); end
    run_op(`ALU_OP_SLT, 32'd7, 32'd5, 16'd0, 7'd2, r, f, t, l);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL slt_7_5: got %h expected 0", r); end
    run_op(`ALU_OP_SLT, 32'hFFFFFFFF, 32'd1, 16'd0, 7'd3, r, f, t, l);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL slt_neg_pos: got %h expected 1", r); end
    run_op(`ALU_OP_SLT, 32'd1, 32'hFFFFFFFF, 16'd0, 7'd4, r, f, t, l);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL slt_pos_neg: got %h expected 0", r); end
    run_op(`ALU_OP_SLTI, 32'd3, 32'd0, 16'h0004, 7'd5, r, f, t, l);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL slti_3_4: got %h expected 1", r); end
    run_op(`ALU_OP_SLTU, 32'hFFFFFFFF, 32'd1, 16'd0, 7'd6, r, f, t, l);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL sltu_max_1: got %h expected 0", r); end
    run_op(`ALU_OP_SLTI, 32'd1, 32'd0, 16'hFFFF, 7'd7, r, f, t, l);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL slti_1_m1: got %h expected 0", r); end
  endtask

  task automatic test_backpressure();
    stream(4, 7'd1, 32'h0000_001C, 14);
    checks++; if (s_out_tag.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", s_out_tag.size()); end
    for (int i = 0; i < 4 && i < s_out_tag.size(); i++) begin
      checks++; if (s_out_tag[i] !== 7'(i + 1) || s_out_res[i] !== 32'((i + 1) * 17)) begin
        errors++; $display("FAIL bp_order[%0d]: got tag=%0d res=%0d expected tag=%0d res=%0d", i, s_out_tag[i], s_out_res[i], i + 1, (i + 1) * 17); end
    end
    checks++; if (s_stalled !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", s_stalled); end
    checks++; if (s_unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", s_unstable); end
    checks++; if (s_notready !== 3) begin errors++; $display("FAIL bp_in_ready_low: got %0d cycles expected 3", s_notready); end
  endtask

  task automatic test_back_to_back();
    stream(4, 7'd20, 32'h0, 10);
    checks++; if (s_out_tag.size() !== 4 || s_acc_cyc.size() !== 4) begin
      errors++; $display("FAIL b2b_count: got out=%0d acc=%0d expected 4/4", s_out_tag.size(), s_acc_cyc.size()); end
    else begin
      checks++; if (s_acc_cyc[0] !== 0 || s_acc_cyc[3] !== 3) begin
        errors++; $display("FAIL b2b_accept: got first=%0d last=%0d expected 0/3", s_acc_cyc[0], s_acc_cyc[3]); end
      checks++; if (s_out_cyc[0] !== 2 || s_out_cyc[3] !== 5) begin
        errors++; $display("FAIL b2b_output: got first=%0d last=%0d expected 2/5", s_out_cyc[0], s_out_cyc[3]); end
      checks++; if (s_out_tag[0] !== 7'd20 || s_out_tag[3] !== 7'd23 || s_out_res[3] !== 32'd391) begin
        errors++; $display("FAIL b2b_data: got tag0=%0d tag3=%0d res3=%0d expected 20/23/391", s_out_tag[0], s_out_tag[3], s_out_res[3]); end
    end
    checks++; if (s_notready !== 0) begin errors++; $display("FAIL b2b_in_ready: got %0d stalls expected 0", s_notready); end
  endtask

  task automatic test_flush();
    logic [31:0] r; logic [5:0] f; logic [6:0] t; int l;
    int seen = 0;
    @(negedge clk); bus.out_ready_i = 1'b0; drive(`ALU_OP_ADD, 32'd10, 32'd0, 16'd0, 7'd10);
    @(negedge clk); drive(`ALU_OP_ADD, 32'd11, 32'd0, 16'd0, 7'd11);
    @(negedge clk); drive(`ALU_OP_ADD, 32'd12, 32'd0, 16'd0, 7'd12); bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_in_ready_full: got %b expected 0", bus.in_ready_o); end
    @(negedge clk); bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1; if (bus.out_valid_o) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_killed: got %0d valid cycles expected 0", seen); end
    // Flush on an empty pipe: in_ready stays high, the offered op is dropped
    drive(`ALU_OP_ADD, 32'd14, 32'd0, 16'd0, 7'd14); bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_in_ready_empty: got %b expected 1", bus.in_ready_o); end
    @(negedge clk); bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1; if (bus.out_valid_o) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_drop_offered: got %0d valid cycles expected 0", seen); end
    run_op(`ALU_OP_ADD, 32'd7, 32'd8, 16'd0, 7'd13, r, f, t, l);
    checks++; if (l !== 2 || r !== 32'd15 || t !== 7'd13) begin
      errors++; $display("FAIL post_flush_op: got lat=%0d res=%0d tag=%0d expected 2/15/13", l, r, t); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic [5:0] f; logic [6:0] t; int l;
    logic [5:0] e_max, e_wrap, e_sub;
`ifdef SIMPLE_ALU_OVF_EN
    e_max = F_EXC; e_wrap = F_OK; e_sub = F_OK;
`else
    e_max = F_OK; e_wrap = F_EXC; e_sub = F_EXC;
`endif
    run_op(`ALU_OP_ADD, 32'h7FFFFFFF, 32'd1, 16'd0, 7'd30, r, f, t, l);
    checks++; if (r !== 32'h80000000 || f !== e_max) begin errors++; $display("FAIL add_maxpos: got %h/%b expected 80000000/%b", r, f, e_max); end
    run_op(`ALU_OP_ADD, 32'hFFFFFFFF, 32'd1, 16'd0, 7'd31, r, f, t, l);
    checks++; if (r !== 32'h0 || f !== e_wrap) begin errors++; $display("FAIL add_wrap: got %h/%b expected 0/%b", r, f, e_wrap); end
    run_op(`ALU_OP_SUB, 32'd0, 32'd1, 16'd0, 7'd32, r, f, t, l);
    checks++; if (r !== 32'hFFFFFFFF || f !== e_sub) begin errors++; $display("FAIL sub_0_1: got %h/%b expected ffffffff/%b", r, f, e_sub); end
    run_op(`ALU_OP_ADDU, 32'hFFFFFFFF, 32'd1, 16'd0, 7'd33, r, f, t, l);
    checks++; if (r !== 32'h0 || f !== F_OK) begin errors++; $display("FAIL addu_wrap: got %h/%b expected 0/%b", r, f, F_OK); end
  endtask

  task automatic test_shift_imm();
    logic [31:0] r; logic [5:0] f; logic [6:0] t; int l;
    run_op(`ALU_OP_SRA, 32'h80000000, 32'd0, 16'd4, 7'd40, r, f, t, l);
    checks++; if (r !== 32'hF8000000) begin errors++; $display("FAIL sra_imm: got %h expected f8000000", r); end
    run_op(`ALU_OP_SRLV, 32'h24, 32'h80000000, 16'd0, 7'd41, r, f, t, l);
    checks++; if (r !== 32'h08000000) begin errors++; $display("FAIL srlv_shamt: got %h expected 08000000", r); end
    run_op(`ALU_OP_LUI, 32'd0, 32'd0, 16'h1234, 7'd42, r, f, t, l);
    checks++; if (r !== 32'h12340000) begin errors++; $display("FAIL lui: got %h expected 12340000", r); end
    run_op(`ALU_OP_ORI, 32'h1, 32'd0, 16'h8000, 7'd43, r, f, t, l);
    checks++; if (r !== 32'h00008001) begin errors++; $display("FAIL ori_zext: got %h expected 00008001", r); end
    run_op(`ALU_OP_ADDI, 32'd10, 32'd0, 16'hFFFF, 7'd44, r, f, t, l);
    checks++; if (r !== 32'd9) begin errors++; $display("FAIL addi_sext: got %h expected 9", r); end
    run_op(`ALU_OP_SRAV, 32'd8, 32'h80000000, 16'd0, 7'd45, r, f, t, l);
    checks++; if (r !== 32'hFF800000) begin errors++; $display("FAIL srav: got %h expected ff800000", r); end
    run_op(`ALU_OP_NOP, 32'h55, 32'h66, 16'd0, 7'd46, r, f, t, l);
    checks++; if (r !== 32'h0 || f !== F_NOP || t !== 7'd46) begin errors++; $display("FAIL nop: got %h/%b expected 0/%b", r, f, F_NOP); end
    run_op(6'd63, 32'h55, 32'h66, 16'd0, 7'd47, r, f, t, l);
    checks++; if (r !== 32'h0 || f !== 6'h0) begin errors++; $display("FAIL unlisted_op: got %h/%b expected 0/000000", r, f); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_slt();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_overflow();
    test_shift_imm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simple_alu_pipe.md
Name: simple_alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle simple ALU in the EXEC stage.
- Accepts one integer op per cycle from the issue/regread path through a valid/ready handshake and returns result, flags and tag two cycles later.
- Supports downstream backpressure and a branch-mispredict flush.
- Fixes signed SLT/SLTI comparison for all sign combinations; data and immediate widths are generic.

Parameters:
- DATA_W, 32, operand/result width; must be greater than IMM_W and a power of two.
- IMM_W, 16, immediate width.
- TAG_W, 7, instruction tag (ROB/phys-dest id) carried alongside each op.
- SHAMT_W, $clog2(DATA_W), shift-amount bits taken from immediate or register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  mispredict recovery; kills all in-flight ops.
- in_valid_i  in  1  op present.
- in_ready_o  out  1  block can accept an op this cycle.
- data1_i  in  DATA_W  source operand 1.
- data2_i  in  DATA_W  source operand 2.
- immd_i  in  IMM_W  immediate.
- opcode_i  in  `SIZE_OPCODE_I  codebase opcode (ADD..LUI, NOP).
- tag_i  in  TAG_W  op tag.
- out_valid_o  out  1  result present.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  DATA_W  result.
- flags_o  out  `EXECUTION_FLAGS  {0, executed, 0, valid, exception, mispredict}.
- tag_o  out  TAG_W  tag of the result.

Behaviour:
- Reset (reset=0, asynchronous): s1_valid=0, s2_valid=0, out_valid_o=0, result_o=0, flags_o=0, tag_o=0.
- Stage S1 (operand register):
  - Captures data1, data2, imm, opcode and tag when in_valid_i && in_ready_o.
- Stage S2 (result register):
  - Registers the combinational ALU output computed from S1 contents.
- Latency: exactly 2 cycles from acceptance to out_valid_o when there is no backpressure. Throughput: 1 op/cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready_i.
  - in_ready_o = !s1_valid || s2_adv (combinational).
  - S1 moves to S2 when s1_valid && s2_adv.
  - S2 drains when out_valid_o && out_ready_i.
  - Outputs hold stable while out_valid_o && !out_ready_i.
  - No op is lost or duplicated under any stall pattern.
- Flush: flush_i=1 clears s1_valid and s2_valid at the next edge. An op presented in the flush cycle is dropped. in_ready_o is still driven normally.
- Arithmetic rules:
  - sign_ex_immd = sign-extend imm to DATA_W. ANDI/ORI/XORI/SLTIU zero-extend.
  - LUI = imm << (DATA_W-IMM_W).
  - ADD/ADDI/SUB: exception bit = carry/borrow out of bit DATA_W-1. ADDU/ADDIU/SUBU: exception bit = 0.
  - SLT/SLTI: true signed compare. SLTU/SLTIU: unsigned compare. Result is 1 or 0, zero-extended.
  - SLL/SRL/SRA use imm[SHAMT_W-1:0]. SLLV/SRLV/SRAV shift data2 by data1[SHAMT_W-1:0]. SRA/SRAV are arithmetic shifts.
  - MFHI/MTHI/MFLO/MTLO pass data1.
  - NOP: result 0, flags 6'b000100.
  - Unlisted opcode: result 0, flags 0.
  - All other listed ops: flags = 6'b010100 | exception bit.
- Simultaneous events:
  - Flush and reset together: reset dominates.
  - Drain and accept in the same cycle is allowed (full-throughput bubble-free).

Optional Feature:
- SIMPLE_ALU_OVF_EN defined:
  - ADD/ADDI/SUB set the exception bit on two's-complement signed overflow, i.e. operand signs equal (ADD) or differ (SUB) and the result sign differs from data1.
  - Carry is ignored.
- Undefined: exception bit = carry/borrow out, legacy behaviour.

Test Plan:
- Reset/idle: reset low mid-stream with 2 ops in flight → out_valid_o=0, result_o=0, flags_o=0 immediately. After release, the first accepted op appears 2 cycles later.
- Signed SLT, all sign combos:
  - SLT 5,7 → 1. SLT 7,5 → 0.
  - SLT 0xFFFFFFFF,1 → 1. SLT 1,0xFFFFFFFF → 0.
  - SLTI 3,imm 0x0004 → 1. SLTU 0xFFFFFFFF,1 → 0.
- Backpressure: stream 4 ADDs (tags 1..4), hold out_ready_i=0 for 3 cycles after the first result → in_ready_o drops after S1 fills. Results emerge in tag order 1..4 with none lost. Outputs stable while stalled.
- Flush: accept tags 10, 11; assert flush_i the cycle tag 12 is presented → tags 10..12 never appear on out_valid_o. The next op after flush returns normally at latency 2.
- Overflow flag: ADD 0x7FFFFFFF+1 → exception 1 with SIMPLE_ALU_OVF_EN, 0 without. ADD 0xFFFFFFFF+1 → result 0, exception 0 with the macro, 1 without.
- Shifts/immediates: SRA 0x80000000 by imm 4 → 0xF8000000. SRLV shamt 0x24 → uses 4 → 0x08000000 for data2 0x80000000. LUI imm 0x1234 → 0x12340000. ORI imm 0x8000 → zero-extended.
